ara_wtap_monitor: RTL

ARA_WTAP_MONITOR -- requirements
Module: ara_wtap_monitor

---
 rtl/ara_wtap_pkg.sv | 12 +
 rtl/ara_wtap_monitor_if.sv | 34 +++
 rtl/ara_wtap_fifo.sv | 42 ++++
 rtl/ara_wtap_monitor.sv | 97 +++++++++
 4 files changed

// File: rtl/ara_wtap_pkg.sv
// ara_wtap_pkg: shared FSM type and constants for the W-channel tap monitor.
// Optional feature macro: ARA_WTAP_TIMESTAMP_EN (per-record capture timestamp).
package ara_wtap_pkg;
    localparam int DropCntWidth = 16;
    localparam int MaxCh = 8;
`ifdef ARA_WTAP_TIMESTAMP_EN
    localparam bit TsEn = 1'b1;
`else
    localparam bit TsEn = 1'b0;
`endif
    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_e;
endpackage

// File: rtl/ara_wtap_monitor_if.sv
// ara_wtap_monitor_if: tapped W channels and record stream of the tap monitor.
// Ports: w_valid_i/w_ready_i/w_data_i/w_strb_i (tap), rec_valid_o/rec_ready_i/rec_ch_o/
// rec_data_o/rec_strb_o[/rec_ts_o] (record stream). slave = monitor side, master = environment.
// rec_ts_o and TsWidth exist only with ARA_WTAP_TIMESTAMP_EN.
interface ara_wtap_monitor_if #(
    parameter int NrCh = 2,
    parameter int DataWidth = 256
`ifdef ARA_WTAP_TIMESTAMP_EN
    , parameter int TsWidth = 32
`endif
);
    localparam int ChW = NrCh > 1 ? $clog2(NrCh) : 1;
    logic [NrCh-1:0]                   w_valid_i;
    logic [NrCh-1:0]                   w_ready_i;
    logic [NrCh-1:0][DataWidth-1:0]    w_data_i;
    logic [NrCh-1:0][DataWidth/8-1:0]  w_strb_i;
    logic                              rec_valid_o;
    logic                              rec_ready_i;
    logic [ChW-1:0]                    rec_ch_o;
    logic [DataWidth-1:0]              rec_data_o;
    logic [DataWidth/8-1:0]            rec_strb_o;
`ifdef ARA_WTAP_TIMESTAMP_EN
    logic [TsWidth-1:0]                rec_ts_o;
    modport slave (input w_valid_i, w_ready_i, w_data_i, w_strb_i, rec_ready_i,
                   output rec_valid_o, rec_ch_o, rec_data_o, rec_strb_o, rec_ts_o);
    modport master (output w_valid_i, w_ready_i, w_data_i, w_strb_i, rec_ready_i,
                    input rec_valid_o, rec_ch_o, rec_data_o, rec_strb_o, rec_ts_o);
`else
    modport slave (input w_valid_i, w_ready_i, w_data_i, w_strb_i, rec_ready_i,
                   output rec_valid_o, rec_ch_o, rec_data_o, rec_strb_o);
    modport master (output w_valid_i, w_ready_i, w_data_i, w_strb_i, rec_ready_i,
                    input rec_valid_o, rec_ch_o, rec_data_o, rec_strb_o);
`endif
endinterface

// File: rtl/ara_wtap_fifo.sv
// ara_wtap_fifo: per-channel capture FIFO; a push while full is accepted when a pop happens the same cycle.
// Ports: clk_i, rst_ni (sync, active-low), push/din, pop/dout (head, first-word-fall-through), full, empty.
module ara_wtap_fifo #(
    parameter int Width = 8,
    parameter int Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic [Width-1:0] din,
    input  logic             pop,
    output logic [Width-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(Depth);
    logic [Width-1:0] mem [Depth];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0] cnt;
    logic wr, rd;
    always_comb begin
        full = cnt == (AW+1)'(Depth);
        empty = cnt == '0;
        rd = pop && !empty;
        wr = push && (!full || rd);
        dout = mem[rptr];
    end
    always_ff @(posedge clk_i) begin
        if (wr) mem[wptr] <= din;
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr <= '0;
            rptr <= '0;
            cnt <= '0;
        end else begin
            if (wr) wptr <= wptr + 1'b1;
            if (rd) rptr <= rptr + 1'b1;
            cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
        end
    end
endmodule

// File: rtl/ara_wtap_monitor.sv
// ara_wtap_monitor: captures qualifying AXI W beats per channel into FIFOs and streams them round-robin as records.
// Ports: clk_i, rst_ni (sync, active-low), en_i, exit_i (tohost), bus (ara_wtap_monitor_if.slave),
// drop_cnt_o (per-channel saturating drops), done_o, fail_o, exit_code_o.
// Macro ARA_WTAP_TIMESTAMP_EN adds a free-running stamp stored with each beat and shown on rec_ts_o.
module ara_wtap_monitor
    import ara_wtap_pkg::*;
#(
    parameter int NrCh = 2,
    parameter int DataWidth = 256,
    parameter int Depth = 4,
    parameter int TsWidth = 32
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               en_i,
    input  logic [63:0]                        exit_i,
    ara_wtap_monitor_if.slave                  bus,
    output logic [NrCh-1:0][DropCntWidth-1:0]  drop_cnt_o,
    output logic                               done_o,
    output logic                               fail_o,
    output logic [62:0]                        exit_code_o
);
    localparam int ChW = NrCh > 1 ? $clog2(NrCh) : 1;
    localparam int SW = DataWidth / 8;
    localparam int EW = DataWidth + SW + (TsEn ? TsWidth : 0);
    state_e state_q, state_d;
    logic [62:0] code_q;
    logic [ChW-1:0] ptr_q, hold_ch_q, rr, grant;
    logic hold_q, hs;
    logic [NrCh-1:0] cap, pop, full, empty;
    logic [EW-1:0] din [NrCh];
    logic [EW-1:0] dout [NrCh];
`ifdef ARA_WTAP_TIMESTAMP_EN
    logic [TsWidth-1:0] ts_q;
    always_ff @(posedge clk_i) begin
        ts_q <= !rst_ni ? '0 : ts_q + 1'b1;
    end
`endif
    for (genvar c = 0; c < NrCh; c++) begin : g_ch
        assign cap[c] = state_q == RUN && en_i && bus.w_valid_i[c] && bus.w_ready_i[c] && |bus.w_strb_i[c];
        assign pop[c] = hs && grant == ChW'(c);
`ifdef ARA_WTAP_TIMESTAMP_EN
        assign din[c] = {ts_q, bus.w_strb_i[c], bus.w_data_i[c]};
`else
        assign din[c] = {bus.w_strb_i[c], bus.w_data_i[c]};
`endif
        ara_wtap_fifo #(.Width(EW), .Depth(Depth)) i_fifo (
            .clk_i(clk_i),
            .rst_ni(rst_ni),
            .push(cap[c]),
            .din(din[c]),
            .pop(pop[c]),
            .dout(dout[c]),
            .full(full[c]),
            .empty(empty[c])
        );
    end
    // Scan downwards so the non-empty channel closest to the pointer wins.
    // Once a record is stalled the grant is frozen so rec_* cannot switch to a newly filled channel.
    always_comb begin
        rr = ptr_q;
        for (int i = NrCh - 1; i >= 0; i--)
            if (!empty[(int'(ptr_q) + i) % NrCh]) rr = ChW'((int'(ptr_q) + i) % NrCh);
        grant = hold_q ? hold_ch_q : rr;
        bus.rec_valid_o = |(~empty);
        bus.rec_ch_o = grant;
        {bus.rec_strb_o, bus.rec_data_o} = dout[grant][DataWidth+SW-1:0];
`ifdef ARA_WTAP_TIMESTAMP_EN
        bus.rec_ts_o = dout[grant][EW-1 -: TsWidth];
`endif
        hs = bus.rec_valid_o && bus.rec_ready_i;
        state_d = state_q == RUN && exit_i[0] ? DRAIN :
                  state_q == DRAIN && &empty ? DONE : state_q;
        done_o = state_q == DONE;
        fail_o = state_q == DONE && code_q != '0;
        exit_code_o = code_q;
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= RUN;
            code_q <= '0;
            ptr_q <= '0;
            hold_q <= 1'b0;
            hold_ch_q <= '0;
            drop_cnt_o <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == RUN && exit_i[0]) code_q <= exit_i[63:1];
            hold_q <= bus.rec_valid_o && !bus.rec_ready_i;
            hold_ch_q <= grant;
            if (hs) ptr_q <= grant == ChW'(NrCh - 1) ? '0 : grant + 1'b1;
            for (int i = 0; i < NrCh; i++)
                if (cap[i] && full[i] && !pop[i] && drop_cnt_o[i] != '1)
                    drop_cnt_o[i] <= drop_cnt_o[i] + 1'b1;
        end
    end
endmodule
